mac_row_feeder: RTL

- West-edge transmitter for the MAC tile array. Generates the per-row 3-bit instruction stream and the matching per-row data word that each row's first tile consumes on its in_w/inst_w inputs.
- Sequences the phases for each mode:
  - WS: weight load, then execute.
  - OS: psum preload, execute, then flush.
- Pulls data vectors from an upstream buffer over a valid/ready handshake.
- Applies the diagonal row skew required by the systolic array.

---
 rtl/mac_row_feeder_if.sv | 15 +
 rtl/mac_row_feeder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mac_row_feeder_if.sv
// Upstream vector stream into the west-edge feeder: one data vector per
// accepted valid/ready handshake, one bw-bit lane per array row.
interface mac_row_feeder_if #(
  parameter int row = 8,
  parameter int bw  = 4
);
  logic [row*bw-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  // Buffer side drives data/valid and watches ready.
  modport master (output in_data, output in_valid, input in_ready);
  // Feeder side consumes data/valid and drives ready.
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/mac_row_feeder.sv
// West-edge transmitter for the MAC tile array. Sequences load/execute
// (WS) or preload/execute/flush (OS), pulls vectors from the upstream
// buffer, and skews each row's inst/data pair diagonally so row r sees
// the word issued at cycle t on cycle t+1+r.
module mac_row_feeder #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int bw     = 4,
  parameter int cnt_bw = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_os,
  input  logic                  act_2b_mode,
  input  logic [cnt_bw-1:0]     num_exec,
  mac_row_feeder_if.slave       up,
  output logic [row*bw-1:0]     out_w,
  output logic [row*3-1:0]      inst_w,
  output logic                  busy,
  output logic                  done
);

  // Phase counter must hold both the longest load (2*col) and the largest
  // execute count (2^cnt_bw - 1) without wrapping.
  localparam int load_w     = $clog2(2*col + 1);
  localparam int pw         = (load_w > cnt_bw) ? load_w : cnt_bw;
  localparam int dw         = (row > 1) ? $clog2(row) : 1;
  localparam int drain_last = (row > 1) ? row - 2 : 0;

  localparam logic [2:0] inst_nop   = 3'b000;
  localparam logic [2:0] inst_load  = 3'b001;
  localparam logic [2:0] inst_exec  = 3'b010;
  localparam logic [2:0] inst_flush = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXEC,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  logic              os_reg;
  logic              mode2_reg;
  logic [cnt_bw-1:0] nexec_reg;
  logic [pw-1:0]     phase_cnt;
  logic [dw-1:0]     drain_cnt;

  logic [pw-1:0]     load_len;
  logic [pw-1:0]     exec_last;
  logic              issue;
  logic [2:0]        issue_inst;
  logic [row*bw-1:0] issue_data;
  state_t            drain_next;

  // WS 2-bit mode loads two bit-planes per column; everything else loads col.
  assign load_len   = (os_reg || !mode2_reg) ? pw'(col) : pw'(2*col);
  assign exec_last  = pw'(nexec_reg) - pw'(1);
  // A single-row array has no skew stages to wait on.
  assign drain_next = (row > 1) ? DRAIN : DONE;

  // Upstream data is only consumed while loading or executing.
  assign up.in_ready = (state == LOAD) || (state == EXEC);

  // Word entering the skew chain this cycle: a real vector, a flush
  // vector, or a zero bubble when upstream has nothing valid.
  always_comb begin
    issue_inst = inst_nop;
    issue_data = '0;
    issue      = 1'b0;
    case (state)
      LOAD: if (up.in_valid) begin
        issue_inst = inst_load;
        issue_data = up.in_data;
        issue      = 1'b1;
      end
      EXEC: if (up.in_valid) begin
        issue_inst = inst_exec;
        issue_data = up.in_data;
        issue      = 1'b1;
      end
      FLUSH: begin
        issue_inst = inst_flush;
        issue      = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer: phase transitions happen on the cycle the last vector of a
  // phase issues, so phases abut with no idle gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      os_reg    <= 1'b0;
      mode2_reg <= 1'b0;
      nexec_reg <= '0;
      phase_cnt <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      done <= (state == DONE);
      if (state != DRAIN) drain_cnt <= '0;
      case (state)
        IDLE: begin
          phase_cnt <= '0;
          if (start) begin
            os_reg    <= is_os;
            mode2_reg <= act_2b_mode;
            nexec_reg <= num_exec;
            state     <= LOAD;
          end
        end
        LOAD: if (issue) begin
          if (phase_cnt == load_len - pw'(1)) begin
            phase_cnt <= '0;
            if (nexec_reg != '0) state <= EXEC;
            else if (os_reg)     state <= FLUSH;
            else                 state <= drain_next;
          end else begin
            phase_cnt <= phase_cnt + pw'(1);
          end
        end
        EXEC: if (issue) begin
          if (phase_cnt == exec_last) begin
            phase_cnt <= '0;
            state     <= os_reg ? FLUSH : drain_next;
          end else begin
            phase_cnt <= phase_cnt + pw'(1);
          end
        end
        FLUSH: begin
          if (phase_cnt == pw'(col - 1)) begin
            phase_cnt <= '0;
            state     <= drain_next;
          end else begin
            phase_cnt <= phase_cnt + pw'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == dw'(drain_last)) state <= DONE;
          else drain_cnt <= drain_cnt + dw'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Per-row skew chains: row gi carries its inst/data pair through gi+1
  // register stages, inst and data side by side.
  generate
    for (genvar gi = 0; gi < row; gi++) begin : g_lane
      logic [bw+2:0] chain [0:gi];

      // Shift the lane's word one stage per cycle.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k <= gi; k++) chain[k] <= '0;
        end else begin
          chain[0] <= {issue_inst, issue_data[gi*bw +: bw]};
          for (int k = 1; k <= gi; k++) chain[k] <= chain[k-1];
        end
      end

      assign out_w[gi*bw +: bw] = chain[gi][bw-1:0];
      assign inst_w[gi*3 +: 3]  = chain[gi][bw+2:bw];
    end
  endgenerate

endmodule
